instr_imm_encoder: RTL and testbench
====================================

INSTR_IMM_ENCODER -- requirements
Module: instr_imm_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the error counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rstn, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high on a rising edge.
REQ-006 SHALL have port fmt, input, 3, format: 0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT, 6-7 illegal.
REQ-007 SHALL have port imm, input, 32, full immediate value to pack.
REQ-008 SHALL have ports opcode (7), rd (5), rs1 (5), rs2 (5), funct3 (3) and funct7 (7), inputs, non-immediate instruction fields.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts when out_valid and out_ready are both high.
REQ-011 SHALL have port instr, output, 32, encoded instruction word.
REQ-012 SHALL have port err, output, 1, result flagged unencodable; qualified by out_valid.
REQ-013 SHALL have port err_cnt, output, CNT_W, count of error results accepted at the output.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers the request plus its range-check result; stage 2 registers the packed word. Each stage has its own valid bit.
REQ-015 Latency SHALL be 2 cycles from input acceptance to out_valid when not stalled. Throughput SHALL be 1 per cycle.
REQ-016 in_ready SHALL be high when stage 1 is empty, or when stage 1 advances in the same cycle. Stage 1 advances when stage 2 is empty or out_ready is high.
REQ-017 While out_valid is high and out_ready is low, instr, err and out_valid SHALL hold stable. No request is dropped or duplicated.
REQ-018 Range check for I and S formats: imm SHALL lie in -2048..2047.
REQ-019 Range check for B format: imm SHALL lie in -4096..4094 and imm[0] SHALL be 0.
REQ-020 Range check for U format: imm[11:0] SHALL be 0.
REQ-021 Range check for J format: imm[31:21] SHALL be 0 and imm[0] SHALL be 0. This is zero-extended, matching the core's J-immediate extension.
REQ-022 Range check for SHAMT format: imm[31:5] SHALL be 0.
REQ-023 An illegal fmt value SHALL flag an error.
REQ-024 Packing SHALL place opcode at [6:0] for every format.
REQ-025 I packing: imm[11:0] at [31:20], rs1 at [19:15], funct3 at [14:12], rd at [11:7].
REQ-026 S packing: imm[11:5] at [31:25], rs2 at [24:20], rs1 at [19:15], funct3 at [14:12], imm[4:0] at [11:7].
REQ-027 B packing: imm[12] at [31], imm[10:5] at [30:25], rs2, rs1 and funct3 as for S, imm[4:1] at [11:8], imm[11] at [7].
REQ-028 U packing: imm[31:12] at [31:12], rd at [11:7].
REQ-029 J packing: imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12], rd at [11:7].
REQ-030 SHAMT packing: funct7 at [31:25], imm[4:0] at [24:20], rs1, funct3 and rd as for I.
REQ-031 On error, instr SHALL be 32'h00000013 (NOP) and err SHALL be 1. On success, err SHALL be 0.
REQ-032 err_cnt SHALL increment by 1 on each output handshake with err=1. It saturates at all-ones and does not wrap.
REQ-033 Simultaneous input acceptance and output handshake in the same cycle SHALL be supported without a bubble.

Reset
REQ-034 While rstn is low at a clock edge, both valid bits, out_valid and err_cnt SHALL clear to 0, instr SHALL clear to 32'h0, and err SHALL clear to 0.
REQ-035 During reset, in_ready SHALL be 0 and SHALL be 1 on the first cycle after release.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight requests. No output is produced for them after release.

Verification
REQ-037 Directed test: fmt=0, imm=-1, rs1=2, funct3=0, rd=1, opcode=7'h13, out_ready=1 -> 2 cycles later out_valid=1, instr=32'hFFF10093, err=0.
REQ-038 Directed test: fmt=2, imm=-8, rs1=1, rs2=2, funct3=1, opcode=7'h63 -> instr=32'hFE209CE3, err=0. Then imm=3 -> instr=32'h00000013, err=1, err_cnt=1.
REQ-039 Directed test: fmt=4, imm=32'h00000800, rd=1, opcode=7'h6F -> instr=32'h001000EF. Then fmt=4, imm=-2 -> err=1.
REQ-040 Directed test: stream 4 back-to-back U requests with out_ready low for 3 cycles -> in_ready drops after 2 accepts. Outputs then emerge in order with none lost, and out_valid/instr stay stable while stalled.
REQ-041 Directed test: fmt=6 while stalled, then rstn low for 1 cycle -> out_valid=0, err_cnt=0, no output after release.
REQ-042 Directed test: CNT_W=2 with 5 error requests -> err_cnt stays at 3.

Source files
------------

// File: rtl/instr_imm_encoder.sv
// rtl/instr_imm_encoder.sv - two-stage immediate range-check and instruction packer
//
// Purpose:
//   Accepts a request carrying an instruction format, a full 32-bit immediate
//   and the non-immediate fields. Stage 1 registers the request together with
//   the result of checking that the immediate fits the chosen format. Stage 2
//   registers the packed instruction word, or a NOP with err set when the
//   immediate cannot be encoded. Each stage has its own valid bit, so one
//   request per cycle can flow through with a latency of two cycles.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   in_valid / in_ready    request handshake
//   fmt                    0=I 1=S 2=B 3=U 4=J 5=SHAMT, 6-7 illegal
//   imm                    immediate to pack
//   opcode, rd, rs1, rs2,
//   funct3, funct7         non-immediate instruction fields
//   out_valid / out_ready  result handshake
//   instr, err             packed word and unencodable flag (qualified by out_valid)
//   err_cnt                saturating count of error results accepted at the output

module instr_imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0]  FMT_I     = 3'd0;
  localparam logic [2:0]  FMT_S     = 3'd1;
  localparam logic [2:0]  FMT_B     = 3'd2;
  localparam logic [2:0]  FMT_U     = 3'd3;
  localparam logic [2:0]  FMT_J     = 3'd4;
  localparam logic [2:0]  FMT_SHAMT = 3'd5;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  // Stage 1 registers
  logic             s1_valid_q,  s1_valid_d;
  logic             s1_err_q,    s1_err_d;
  logic [2:0]       s1_fmt_q,    s1_fmt_d;
  logic [31:0]      s1_imm_q,    s1_imm_d;
  logic [6:0]       s1_opcode_q, s1_opcode_d;
  logic [4:0]       s1_rd_q,     s1_rd_d;
  logic [4:0]       s1_rs1_q,    s1_rs1_d;
  logic [4:0]       s1_rs2_q,    s1_rs2_d;
  logic [2:0]       s1_funct3_q, s1_funct3_d;
  logic [6:0]       s1_funct7_q, s1_funct7_d;

  // Stage 2 registers
  logic             s2_valid_q,  s2_valid_d;
  logic [31:0]      s2_instr_q,  s2_instr_d;
  logic             s2_err_q,    s2_err_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

  logic             s2_free;
  logic             in_fire;
  logic             s1_move;
  logic             out_fire;
  logic             range_err;
  logic [31:0]      packed_word;

  // Stage 2 can take a new word when it is empty or is being drained this cycle.
  assign s2_free  = !s2_valid_q || out_ready;
  // in_ready is forced low while reset is asserted so nothing is accepted then.
  assign in_ready = rstn && (!s1_valid_q || s2_free);
  assign in_fire  = in_valid && in_ready;
  assign s1_move  = s1_valid_q && s2_free;
  assign out_fire = s2_valid_q && out_ready;

  // Range check on the incoming request; the verdict travels with it in stage 1.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      // Signed 12-bit: bits [31:11] must be a pure sign extension.
      FMT_I, FMT_S: range_err = !((&imm[31:11]) || (~|imm[31:11]));
      // Signed 13-bit even offset: bits [31:12] sign extension, bit 0 clear.
      FMT_B:        range_err = !((&imm[31:12]) || (~|imm[31:12])) || imm[0];
      FMT_U:        range_err = |imm[11:0];
      // J immediate is treated as zero-extended 21-bit even value.
      FMT_J:        range_err = (|imm[31:21]) || imm[0];
      FMT_SHAMT:    range_err = |imm[31:5];
      default:      range_err = 1'b1;
    endcase
  end

  // Pack the stage-1 request into an instruction word.
  always_comb begin
    packed_word = NOP_WORD;
    if (!s1_err_q) begin
      case (s1_fmt_q)
        FMT_I:     packed_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
        FMT_S:     packed_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                  s1_imm_q[4:0], s1_opcode_q};
        FMT_B:     packed_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                  s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
        FMT_U:     packed_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
        FMT_J:     packed_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                  s1_rd_q, s1_opcode_q};
        FMT_SHAMT: packed_word = {s1_funct7_q, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q,
                                  s1_rd_q, s1_opcode_q};
        default:   packed_word = NOP_WORD;
      endcase
    end
  end

  // Stage 1 next state
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_err_d    = s1_err_q;
    s1_fmt_d    = s1_fmt_q;
    s1_imm_d    = s1_imm_q;
    s1_opcode_d = s1_opcode_q;
    s1_rd_d     = s1_rd_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_funct3_d = s1_funct3_q;
    s1_funct7_d = s1_funct7_q;
    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_err_d    = range_err;
      s1_fmt_d    = fmt;
      s1_imm_d    = imm;
      s1_opcode_d = opcode;
      s1_rd_d     = rd;
      s1_rs1_d    = rs1;
      s1_rs2_d    = rs2;
      s1_funct3_d = funct3;
      s1_funct7_d = funct7;
    end else if (s1_move) begin
      s1_valid_d  = 1'b0;
    end
  end

  // Stage 2 next state and error counter
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
      // Word and flag only change when a real request moves in; they hold otherwise.
      if (s1_valid_q) begin
        s2_instr_d = packed_word;
        s2_err_d   = s1_err_q;
      end
    end
    if (out_fire && s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_fmt_q    <= 3'd0;
      s1_imm_q    <= 32'h0;
      s1_opcode_q <= 7'h0;
      s1_rd_q     <= 5'h0;
      s1_rs1_q    <= 5'h0;
      s1_rs2_q    <= 5'h0;
      s1_funct3_q <= 3'h0;
      s1_funct7_q <= 7'h0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= 32'h0;
      s2_err_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_imm_q    <= s1_imm_d;
      s1_opcode_q <= s1_opcode_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_funct3_q <= s1_funct3_d;
      s1_funct7_q <= s1_funct7_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = s2_instr_q;
  assign err       = s2_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// tb/tb_instr_imm_encoder.sv - directed bench for instr_imm_encoder

module tb_instr_imm_encoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  fmt;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic        in_ready, out_valid, err;
  logic [31:0] instr;
  logic [15:0] err_cnt;

  logic        in_ready2, out_valid2, err2;
  logic [31:0] instr2;
  logic [1:0]  err_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_imm_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .err_cnt(err_cnt)
  );

  instr_imm_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .out_valid(out_valid2), .out_ready(out_ready),
    .instr(instr2), .err(err2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction with out_ready high: accept, wait, check, drain.
  task automatic single(input string tag, input logic [2:0] f, input logic [31:0] v,
                        input logic [31:0] exp_instr, input logic exp_err);
    fmt = f;
    imm = v;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, instr, exp_instr);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    tick();
  endtask

  logic [31:0] u_imm [4];
  logic [31:0] prev_instr;
  logic        prev_stall;
  int          sent, got;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = 3'd0; imm = 32'h0; opcode = 7'h13; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3;
    funct3 = 3'd0; funct7 = 7'h00;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    rstn = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // I format, imm=-1
    opcode = 7'h13; rd = 5'd1; rs1 = 5'd2; funct3 = 3'd0;
    single("i_neg1", 3'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);

    // B format valid then odd offset
    opcode = 7'h63; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd1;
    single("b_neg8", 3'd2, 32'hFFFF_FFF8, 32'hFE20_9CE3, 1'b0);
    single("b_odd", 3'd2, 32'd3, 32'h0000_0013, 1'b1);
    chk("b_err_cnt", {16'b0, err_cnt}, 32'd1);

    // J format, zero-extended immediate
    opcode = 7'h6F; rd = 5'd1;
    single("j_800", 3'd4, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    single("j_neg2", 3'd4, 32'hFFFF_FFFE, 32'h0000_0013, 1'b1);
    chk("j_err_cnt", {16'b0, err_cnt}, 32'd2);

    // Boundaries with common fields
    opcode = 7'h13; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; funct3 = 3'd1; funct7 = 7'h20;
    single("i_max", 3'd0, 32'd2047, 32'h7FF1_1093, 1'b0);
    single("i_min", 3'd0, 32'hFFFF_F800, 32'h8001_1093, 1'b0);
    single("i_over", 3'd0, 32'd2048, 32'h0000_0013, 1'b1);
    single("s_under", 3'd1, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1);
    single("s_pack", 3'd1, 32'd2021, 32'h7E31_1293, 1'b0);
    single("b_max", 3'd2, 32'd4094, 32'h7E31_1F93, 1'b0);
    single("b_over", 3'd2, 32'd4096, 32'h0000_0013, 1'b1);
    single("u_low", 3'd3, 32'h0000_0800, 32'h0000_0013, 1'b1);
    single("sh_31", 3'd5, 32'd31, 32'h41F1_1093, 1'b0);
    single("sh_32", 3'd5, 32'd32, 32'h0000_0013, 1'b1);
    single("fmt7", 3'd7, 32'd0, 32'h0000_0013, 1'b1);
    chk("bnd_err_cnt", {16'b0, err_cnt}, 32'd8);

    // Back-to-back U stream with a 3-cycle output stall
    u_imm[0] = 32'h1234_5000; u_imm[1] = 32'hABCD_E000;
    u_imm[2] = 32'h0000_1000; u_imm[3] = 32'hFFFF_F000;
    opcode = 7'h37; rd = 5'd5; fmt = 3'd3;
    sent = 0; got = 0; prev_stall = 1'b0; prev_instr = 32'h0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      out_ready = (c >= 3);
      in_valid  = (sent < 4);
      imm       = (sent < 4) ? u_imm[sent] : 32'h0;
      #1;
      if (c == 2) chk("stall_in_ready_low", {31'b0, in_ready}, 32'd0);
      if (prev_stall) begin
        chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_hold_instr", instr, prev_instr);
      end
      if (out_valid && out_ready) begin
        chk("stream_instr", instr, u_imm[got] | 32'h0000_02B7);
        chk("stream_err", {31'b0, err}, 32'd0);
        got++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_instr = instr;
      tick();
    end
    in_valid = 1'b0;
    chk("stream_count", got, 32'd4);

    // Illegal format caught in a stall, then reset discards everything
    out_ready = 1'b0; fmt = 3'd6; imm = 32'h0; in_valid = 1'b1;
    tick();
    fmt = 3'd0;
    tick();
    in_valid = 1'b0;
    chk("stall_fmt6_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_fmt6_err", {31'b0, err}, 32'd1);
    rstn = 1'b0;
    tick();
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rstn = 1'b1; out_ready = 1'b1;
    #1;
    chk("mid_rst_release_ready", {31'b0, in_ready}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("no_output_after_rst", {31'b0, out_valid}, 32'd0);
    end

    // Saturation of the narrow counter
    fmt = 3'd7; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("cnt16_errs", {16'b0, err_cnt}, 32'd5);
    chk("cnt2_saturated", {30'b0, err_cnt2}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
